// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the shift register / deserializer pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int MSB_FIRST_ORDER = 1;
    localparam int LSB_FIRST_ORDER = 0;

    // Counter width for 0..width-1, never narrower than one bit
    function automatic int clog2(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_deserializer_if.sv
// ============================================================================
// Module      : shift_deserializer_if
// Description : Serial input and valid/ready word output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_deserializer_if #(
    parameter int WIDTH = 8
) ();

    logic             serial_in;
    logic             serial_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             busy;

    modport master (
        input  serial_in,
        input  serial_valid,
        input  frame_start,
        input  data_ready,
        output data_out,
        output data_valid,
        output overrun,
        output busy
    );

    modport slave (
        output serial_in,
        output serial_valid,
        output frame_start,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  overrun,
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/shift_hold_reg.sv
// ============================================================================
// Module      : shift_hold_reg
// Description : Single-entry valid/ready holding register, drops on full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_hold_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic             ready,
    output logic      [WIDTH-1:0] data,
    output logic                  valid,
    output logic                  overrun
);

    logic             w_free;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // A consumer taking the current word this cycle frees the slot for a new one
    assign w_free = !r_valid || ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= load && !w_free;
            if (load && w_free) begin
                r_data  <= load_data;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/shift_deserializer.sv
// ============================================================================
// Module      : shift_deserializer
// Description : Serial-to-parallel receiver with valid/ready word output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
    input  wire logic              clock,
    input  wire logic              reset,
    shift_deserializer_if.master   bus
);

    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;
    logic [CW-1:0]    w_cnt_base;
    logic             w_complete;

    // frame_start restarts the word with the current bit as bit 0
    assign w_base     = bus.frame_start ? '0 : r_shift;
    assign w_cnt_base = bus.frame_start ? '0 : r_cnt;
    assign w_complete = bus.serial_valid && (w_cnt_base == CW'(WIDTH - 1));

    generate
        if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb_first
            assign w_next = {w_base[WIDTH-2:0], bus.serial_in};
        end else begin : g_lsb_first
            assign w_next = {bus.serial_in, w_base[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (bus.serial_valid) begin
            if (w_complete) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_shift <= w_next;
                r_cnt   <= w_cnt_base + CW'(1);
                r_busy  <= 1'b1;
            end
        end
    end

    assign bus.busy = r_busy;

    shift_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .load      (w_complete),
        .load_data (w_next),
        .ready     (bus.data_ready),
        .data      (bus.data_out),
        .valid     (bus.data_valid),
        .overrun   (bus.overrun)
    );

endmodule

`default_nettype wire
